// File: rtl/cache_victim_sel.sv
// Random-replacement victim selector: gathers LFSR bits into a way index and picks a fill victim.
// Define VICTIM_SEL_PREFER_INVALID_EN to pick free (invalid) ways before any random choice.
module cache_victim_sel #(
  parameter int NUM_WAYS = 4,
  parameter int WAY_W    = $clog2(NUM_WAYS)
) (
  input  logic                clk,
  input  logic                rst_aL,
  input  logic                rand_bit,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [NUM_WAYS-1:0] req_valid_ways,
  input  logic [NUM_WAYS-1:0] way_busy,
  output logic                victim_valid,
  input  logic                victim_ready,
  output logic [WAY_W-1:0]    victim_way,
  output logic [NUM_WAYS-1:0] victim_onehot,
  output logic                victim_evict
);

  typedef enum logic [1:0] {IDLE, PICK, HOLD} state_t;

  state_t              state_q, state_d;
  logic [WAY_W-1:0]    rnd_q;
  logic [NUM_WAYS-1:0] vld_q;
  logic [NUM_WAYS-1:0] elig;
  logic                pick_found;
  logic [WAY_W-1:0]    pick_way;
  logic                pick_evict;
  logic [NUM_WAYS-1:0] pick_onehot;
  logic [WAY_W-1:0]    idx;

  // The accumulator runs in every state so the start index keeps changing while PICK retries.
  if (WAY_W == 1) begin : g_rnd_one
    always_ff @(posedge clk) begin
      if (!rst_aL) rnd_q <= '0;
      else         rnd_q <= rand_bit;
    end
  end else begin : g_rnd_multi
    always_ff @(posedge clk) begin
      if (!rst_aL) rnd_q <= '0;
      else         rnd_q <= {rnd_q[WAY_W-2:0], rand_bit};
    end
  end

  // Wraparound search from rnd_q; NUM_WAYS is a power of two so the adder wraps naturally.
  always_comb begin
    elig        = ~way_busy;
    pick_found  = 1'b0;
    pick_way    = '0;
    pick_evict  = 1'b0;
    idx         = '0;
    for (int i = 0; i < NUM_WAYS; i++) begin
      idx = rnd_q + WAY_W'(i);
      if (!pick_found && elig[idx]) begin
        pick_found = 1'b1;
        pick_way   = idx;
        pick_evict = vld_q[idx];
      end
    end
`ifdef VICTIM_SEL_PREFER_INVALID_EN
    for (int i = NUM_WAYS - 1; i >= 0; i--) begin
      if (elig[i] && !vld_q[i]) begin
        pick_found = 1'b1;
        pick_way   = WAY_W'(i);
        pick_evict = 1'b0;
      end
    end
`endif
    pick_onehot           = '0;
    pick_onehot[pick_way] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid)    state_d = PICK;
      PICK:    if (pick_found)   state_d = HOLD;
      HOLD:    if (victim_ready) state_d = IDLE;
      default:                   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_aL) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Result registers only load on a successful pick so HOLD outputs stay stable.
  always_ff @(posedge clk) begin
    if (!rst_aL) begin
      vld_q         <= '0;
      victim_way    <= '0;
      victim_onehot <= '0;
      victim_evict  <= 1'b0;
    end else begin
      if (state_q == IDLE && req_valid) vld_q <= req_valid_ways;
      if (state_q == PICK && pick_found) begin
        victim_way    <= pick_way;
        victim_onehot <= pick_onehot;
        victim_evict  <= pick_evict;
      end
    end
  end

  assign req_ready    = rst_aL && (state_q == IDLE);
  assign victim_valid = rst_aL && (state_q == HOLD);

endmodule

// File: tb/tb_cache_victim_sel.sv
// Self-checking bench for cache_victim_sel (NUM_WAYS=4): directed table, corner sequences, random run.
// Honours VICTIM_SEL_PREFER_INVALID_EN the same way the design does.
module tb_cache_victim_sel;

  logic       clk = 1'b0;
  logic       rst_aL;
  logic       rand_bit;
  logic       req_valid;
  logic       req_ready;
  logic [3:0] req_valid_ways;
  logic [3:0] way_busy;
  logic       victim_valid;
  logic       victim_ready;
  logic [1:0] victim_way;
  logic [3:0] victim_onehot;
  logic       victim_evict;

  int tests_run = 0;
  int tests_failed = 0;
  int model_rnd = 0;

  cache_victim_sel #(.NUM_WAYS(4)) dut (
    .clk(clk), .rst_aL(rst_aL), .rand_bit(rand_bit),
    .req_valid(req_valid), .req_ready(req_ready), .req_valid_ways(req_valid_ways),
    .way_busy(way_busy), .victim_valid(victim_valid), .victim_ready(victim_ready),
    .victim_way(victim_way), .victim_onehot(victim_onehot), .victim_evict(victim_evict)
  );

  always #5 clk = ~clk;

  // Random index as the number formed by the last two bits seen at clock edges since reset.
  always @(posedge clk) begin
    if (!rst_aL) model_rnd <= 0;
    else         model_rnd <= (model_rnd * 2 + int'(rand_bit)) % 4;
  end

  typedef struct {
    logic [3:0] vld;
    logic [3:0] busy;
    logic [1:0] rnd;
    int         exp_way;
    bit         exp_evict;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic rv, input logic [3:0] vld, input logic [3:0] busy,
                               input logic rb, input logic vr);
    req_valid      = rv;
    req_valid_ways = vld;
    way_busy       = busy;
    rand_bit       = rb;
    victim_ready   = vr;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests_run++;
    if (actual != expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: actual=%0d required=%0d", name, actual, expected);
    end
  endtask

  function automatic void ref_pick(input logic [3:0] vld, input logic [3:0] busy, input int rnd,
                                   output bit found, output int way, output bit evict);
    found = 0; way = 0; evict = 0;
`ifdef VICTIM_SEL_PREFER_INVALID_EN
    for (int w = 0; w < 4; w++)
      if (!busy[w] && !vld[w]) begin
        found = 1; way = w; evict = 0;
        return;
      end
`endif
    for (int k = 0; k < 4; k++) begin
      int w;
      w = (rnd + k) % 4;
      if (!busy[w]) begin
        found = 1; way = w; evict = vld[w];
        return;
      end
    end
  endfunction

  // From IDLE: shape the accumulator so rnd_q == rnd during the PICK cycle, then accept the request.
  task automatic start_request(input logic [3:0] vld, input logic [1:0] rnd);
    logic [1:0] r;
    r = rnd;
    applyStimulus(1'b0, vld, 4'b0000, r[1], 1'b0);
    step();
    applyStimulus(1'b1, vld, 4'b0000, r[0], 1'b0);
    checkOutput("accept_ready", int'(req_ready), 1);
    step();
    req_valid = 1'b0;
    checkOutput("pick_valid_low", int'(victim_valid), 0);
    checkOutput("pick_ready_low", int'(req_ready), 0);
  endtask

  task automatic release_hold();
    victim_ready = 1'b1;
    step();
    victim_ready = 1'b0;
    checkOutput("idle_ready", int'(req_ready), 1);
    checkOutput("idle_valid", int'(victim_valid), 0);
  endtask

  initial begin
    vecs[0] = '{4'b1011, 4'b0000, 2'd0, 2, 1'b0};
    vecs[1] = '{4'b1111, 4'b0000, 2'd2, 2, 1'b1};
    vecs[2] = '{4'b1111, 4'b1000, 2'd3, 0, 1'b1};
    vecs[3] = '{4'b0000, 4'b0001, 2'd0, 1, 1'b0};
    vecs[4] = '{4'b1110, 4'b0001, 2'd3, 3, 1'b1};
    vecs[5] = '{4'b0101, 4'b0000, 2'd2, 1, 1'b0};
    vecs[6] = '{4'b1111, 4'b0110, 2'd1, 3, 1'b1};
`ifndef VICTIM_SEL_PREFER_INVALID_EN
    vecs[0].exp_way = 0; vecs[0].exp_evict = 1'b1;
    vecs[5].exp_way = 2; vecs[5].exp_evict = 1'b1;
`endif

    // Reset held with a pending request.
    rst_aL = 1'b0;
    applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput("rst_req_ready", int'(req_ready), 0);
      checkOutput("rst_victim_valid", int'(victim_valid), 0);
    end
    rst_aL = 1'b1;
    req_valid = 1'b0;
    #1;
    checkOutput("post_rst_ready", int'(req_ready), 1);
    checkOutput("post_rst_onehot", int'(victim_onehot), 0);
    checkOutput("post_rst_way", int'(victim_way), 0);
    checkOutput("post_rst_evict", int'(victim_evict), 0);

    // Directed table.
    for (int i = 0; i < 7; i++) begin
      start_request(vecs[i].vld, vecs[i].rnd);
      way_busy = vecs[i].busy;
      step();
      checkOutput($sformatf("vec%0d_valid", i), int'(victim_valid), 1);
      checkOutput($sformatf("vec%0d_way", i), int'(victim_way), vecs[i].exp_way);
      checkOutput($sformatf("vec%0d_onehot", i), int'(victim_onehot), 1 << vecs[i].exp_way);
      checkOutput($sformatf("vec%0d_evict", i), int'(victim_evict), int'(vecs[i].exp_evict));
      release_hold();
    end

    // All ways busy: retry in PICK, then only way 1 frees up.
    start_request(4'b1111, 2'd0);
    way_busy = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      rand_bit = 1'($urandom_range(1));
      step();
      checkOutput("busy_valid_low", int'(victim_valid), 0);
      checkOutput("busy_ready_low", int'(req_ready), 0);
    end
    way_busy = 4'b1101;
    step();
    checkOutput("busy_release_valid", int'(victim_valid), 1);
    checkOutput("busy_release_way", int'(victim_way), 1);
    checkOutput("busy_release_evict", int'(victim_evict), 1);

    // Backpressure in HOLD, then reset aborts the result.
    way_busy = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      rand_bit = 1'($urandom_range(1));
      step();
      checkOutput("bp_valid", int'(victim_valid), 1);
      checkOutput("bp_way", int'(victim_way), 1);
      checkOutput("bp_onehot", int'(victim_onehot), 4'b0010);
      checkOutput("bp_ready_low", int'(req_ready), 0);
    end
    rst_aL = 1'b0;
    step();
    checkOutput("abort_valid", int'(victim_valid), 0);
    rst_aL = 1'b1;
    #1;
    checkOutput("abort_ready", int'(req_ready), 1);
    checkOutput("abort_onehot", int'(victim_onehot), 0);

    // Randomized transactions against the reference model.
    for (int t = 0; t < 200; t++) begin
      bit   found;
      int   exp_way;
      bit   exp_evict;
      bit   done;
      logic [3:0] vld;
      vld = 4'($urandom);
      applyStimulus(1'b1, vld, 4'($urandom), 1'($urandom_range(1)), 1'b0);
      checkOutput("rnd_accept_ready", int'(req_ready), 1);
      step();
      req_valid = 1'b0;
      done = 0;
      for (int c = 0; c < 20 && !done; c++) begin
        if (c < 10 && $urandom_range(3) == 0) way_busy = 4'b1111;
        else if (c < 10)                      way_busy = 4'($urandom);
        else                                  way_busy = 4'b0000;
        rand_bit = 1'($urandom_range(1));
        #1;
        checkOutput("rnd_pick_valid_low", int'(victim_valid), 0);
        ref_pick(vld, way_busy, model_rnd, found, exp_way, exp_evict);
        step();
        if (found) begin
          done = 1;
          checkOutput("rnd_valid", int'(victim_valid), 1);
          checkOutput("rnd_way", int'(victim_way), exp_way);
          checkOutput("rnd_onehot", int'(victim_onehot), 1 << exp_way);
          checkOutput("rnd_evict", int'(victim_evict), int'(exp_evict));
        end
      end
      checkOutput("rnd_pick_done", int'(done), 1);
      for (int w = $urandom_range(3); w > 0; w--) begin
        rand_bit = 1'($urandom_range(1));
        step();
        checkOutput("rnd_hold_way", int'(victim_way), exp_way);
        checkOutput("rnd_hold_valid", int'(victim_valid), 1);
      end
      rand_bit = 1'($urandom_range(1));
      release_hold();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
